// File: rtl/common_cross_buffer4_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// common_cross_buffer4_dispatch_pkg
// Shared constants for the 1-to-4 dispatch cross buffer and its per-port slots.
//   NUM_PORTS : number of downstream ports (4)
//   DEST_W    : width of a destination index (2)
//   MASK_W    : width of a broadcast destination mask (4)
//   DEST_IN_W : width of prev_i_dest actually used by the top level; it is the
//               mask width when COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN is
//               defined, otherwise the index width.
// -----------------------------------------------------------------------------
package common_cross_buffer4_dispatch_pkg;

   localparam int NUM_PORTS = 4;
   localparam int DEST_W    = 2;
   localparam int MASK_W    = 4;

`ifdef COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN
   localparam int DEST_IN_W = MASK_W;
`else
   localparam int DEST_IN_W = DEST_W;
`endif

endpackage

// File: rtl/common_dispatch_slot.sv
// -----------------------------------------------------------------------------
// common_dispatch_slot
// One downstream port of the dispatch buffer: a 1-entry bypass (skid) buffer.
// While empty, a selected beat is forwarded combinationally; if the consumer is
// not ready it is latched instead. While full, the stored beat is presented and
// no new beat is taken; it leaves when the consumer is ready.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   sel        : beat for this port is being accepted upstream this cycle
//   in_data    : upstream payload
//   out_ready  : consumer ready
//   out_valid  : port beat valid
//   out_data   : port payload (0 when idle)
//   full       : registered occupancy, used for upstream ready
// -----------------------------------------------------------------------------
module common_dispatch_slot
   import common_cross_buffer4_dispatch_pkg::*;
#(
   parameter int BUFFER_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sel,
   input  logic [BUFFER_WIDTH-1:0] in_data,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [BUFFER_WIDTH-1:0] out_data,
   output logic                    full
);

   logic                    full_q;
   logic [BUFFER_WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (full_q) begin
         if (out_ready) begin
            full_q <= 1'b0;
         end
      end else if (sel && !out_ready) begin
         full_q <= 1'b1;
         data_q <= in_data;
      end
   end

   // The stored entry always has priority; sel is never asserted while full
   // because the top gates selection with the upstream ready.
   always_comb begin
      out_valid = full_q | sel;
      out_data  = '0;
      if (full_q) begin
         out_data = data_q;
      end else if (sel) begin
         out_data = in_data;
      end
   end

   assign full = full_q;

endmodule

// File: rtl/common_cross_buffer4_dispatch.sv
// -----------------------------------------------------------------------------
// common_cross_buffer4_dispatch
// 1-to-4 dispatch cross buffer: routes one valid/ready stream to one of four
// ports by prev_i_dest. Each port has a 1-entry bypass buffer, so a stalled
// port only blocks the input when a beat is addressed to it while it is full.
// prev_o_ready depends only on registered occupancy and prev_i_dest, never on
// any downstream ready.
// Optional feature: COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN turns
// prev_i_dest into a 4-bit target mask; a beat is accepted only when every
// targeted port is empty, and a zero mask is accepted and discarded.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   prev_i_data/dest/valid, prev_o_ready : upstream stream
//   nextN_o_data/valid, nextN_i_ready    : downstream port N, N = 0..3
// -----------------------------------------------------------------------------
module common_cross_buffer4_dispatch
   import common_cross_buffer4_dispatch_pkg::*;
#(
   parameter int BUFFER_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [BUFFER_WIDTH-1:0] prev_i_data,
   input  logic [DEST_IN_W-1:0]    prev_i_dest,
   input  logic                    prev_i_valid,
   output logic                    prev_o_ready,
   output logic [BUFFER_WIDTH-1:0] next0_o_data,
   output logic                    next0_o_valid,
   input  logic                    next0_i_ready,
   output logic [BUFFER_WIDTH-1:0] next1_o_data,
   output logic                    next1_o_valid,
   input  logic                    next1_i_ready,
   output logic [BUFFER_WIDTH-1:0] next2_o_data,
   output logic                    next2_o_valid,
   input  logic                    next2_i_ready,
   output logic [BUFFER_WIDTH-1:0] next3_o_data,
   output logic                    next3_o_valid,
   input  logic                    next3_i_ready
);

   logic [NUM_PORTS-1:0]    target;
   logic [NUM_PORTS-1:0]    full;
   logic [NUM_PORTS-1:0]    sel;
   logic [NUM_PORTS-1:0]    port_ready;
   logic [NUM_PORTS-1:0]    port_valid;
   logic [BUFFER_WIDTH-1:0] port_data [NUM_PORTS];

   // Destination decode into a one-hot (or multi-hot) target set.
   always_comb begin
`ifdef COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN
      target = prev_i_dest;
`else
      target = '0;
      target[prev_i_dest] = 1'b1;
`endif
   end

   // Accept only when every targeted port is empty; an empty target set is
   // always accepted. Selection is gated by acceptance so that a broadcast
   // never reaches a subset of its targets.
   assign prev_o_ready = ~|(target & full);
   assign sel          = target & {NUM_PORTS{prev_i_valid & prev_o_ready}};

   assign port_ready = {next3_i_ready, next2_i_ready, next1_i_ready, next0_i_ready};

   for (genvar n = 0; n < NUM_PORTS; n++) begin : g_slot
      common_dispatch_slot #(
         .BUFFER_WIDTH(BUFFER_WIDTH)
      ) u_slot (
         .clk      (clk),
         .reset    (reset),
         .sel      (sel[n]),
         .in_data  (prev_i_data),
         .out_ready(port_ready[n]),
         .out_valid(port_valid[n]),
         .out_data (port_data[n]),
         .full     (full[n])
      );
   end

   assign next0_o_valid = port_valid[0];
   assign next1_o_valid = port_valid[1];
   assign next2_o_valid = port_valid[2];
   assign next3_o_valid = port_valid[3];
   assign next0_o_data  = port_data[0];
   assign next1_o_data  = port_data[1];
   assign next2_o_data  = port_data[2];
   assign next3_o_data  = port_data[3];

endmodule

// File: tb/tb_common_cross_buffer4_dispatch.sv
// -----------------------------------------------------------------------------
// tb_common_cross_buffer4_dispatch
// Directed and randomized bench for the 1-to-4 dispatch cross buffer. The
// reference keeps one queue per port holding beats that could not be handed
// over on arrival, and derives the expected port outputs and upstream ready
// from those queues. Broadcast steps are built only when
// COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_common_cross_buffer4_dispatch;
   import common_cross_buffer4_dispatch_pkg::*;

   localparam int W = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [W-1:0]         data;
   logic [DEST_IN_W-1:0] dest;
   logic                 valid;
   logic                 prev_o_ready;
   logic [3:0]           rdy;
   logic [3:0]           o_valid;
   logic [W-1:0]         o_data [4];

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;

   typedef logic [W-1:0] bq_t [$];
   bq_t mq [4];

   always #5 clk = ~clk;

   common_cross_buffer4_dispatch #(.BUFFER_WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .prev_i_data  (data),
      .prev_i_dest  (dest),
      .prev_i_valid (valid),
      .prev_o_ready (prev_o_ready),
      .next0_o_data (o_data[0]),
      .next0_o_valid(o_valid[0]),
      .next0_i_ready(rdy[0]),
      .next1_o_data (o_data[1]),
      .next1_o_valid(o_valid[1]),
      .next1_i_ready(rdy[1]),
      .next2_o_data (o_data[2]),
      .next2_o_valid(o_valid[2]),
      .next2_i_ready(rdy[2]),
      .next3_o_data (o_data[3]),
      .next3_o_valid(o_valid[3]),
      .next3_i_ready(rdy[3])
   );

   function automatic logic [3:0] tmask(input logic [DEST_IN_W-1:0] d);
`ifdef COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN
      return d;
`else
      return 4'b0001 << d;
`endif
   endfunction

   function automatic logic model_ready();
      logic [3:0] tg;
      logic       r;
      tg = tmask(dest);
      r  = 1'b1;
      for (int n = 0; n < 4; n++) if (tg[n] && mq[n].size() != 0) r = 1'b0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0] tg;
      logic       er;
      logic       ev;
      logic [W-1:0] ed;
      tg = tmask(dest);
      er = model_ready();
      chk($sformatf("%s.ready", tag), 32'(prev_o_ready), 32'(er));
      for (int n = 0; n < 4; n++) begin
         ev = 1'b0;
         ed = '0;
         if (mq[n].size() != 0) begin
            ev = 1'b1;
            ed = mq[n][0];
         end else if (valid && tg[n] && er) begin
            ev = 1'b1;
            ed = data;
         end
         chk($sformatf("%s.valid%0d", tag, n), 32'(o_valid[n]), 32'(ev));
         chk($sformatf("%s.data%0d", tag, n), 32'(o_data[n]), 32'(ed));
      end
   endtask

   // Advance the reference across a clock edge using the inputs held there.
   task automatic model_edge();
      logic [3:0] tg;
      logic       acc;
      logic [3:0] was_full;
      if (reset) begin
         for (int n = 0; n < 4; n++) mq[n].delete();
         return;
      end
      tg  = tmask(dest);
      acc = valid && model_ready();
      for (int n = 0; n < 4; n++) begin
         was_full[n] = (mq[n].size() != 0);
         if (was_full[n] && rdy[n]) void'(mq[n].pop_front());
         if (acc && tg[n] && !was_full[n] && !rdy[n]) mq[n].push_back(data);
      end
   endtask

   task automatic step(input string tag);
      #3;
      check_all(tag);
      if (valid && prev_o_ready) acc_cnt++;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input logic v, input int d, input int dv, input logic [3:0] r);
      valid = v;
      dest  = DEST_IN_W'(d);
      data  = W'(dv);
      rdy   = r;
   endtask

   initial begin
      int a0;
      logic stalled;
      reset = 1'b1;
      drive(1'b0, 0, 0, 4'b0000);
      @(posedge clk);
      model_edge();
      @(posedge clk);
      model_edge();
      #1;
      reset = 1'b0;

      // Reset then idle
      step("idle");
      chk("idle.valid_vec", 32'(o_valid), 32'h0);
      chk("idle.ready", 32'(prev_o_ready), 32'h1);

      // Bypass to port 2
`ifdef COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN
      drive(1'b1, 4'b0100, 8'hA5, 4'b0100);
`else
      drive(1'b1, 2, 8'hA5, 4'b0100);
`endif
      #3;
      chk("byp.valid_vec", 32'(o_valid), 32'h4);
      chk("byp.data2", 32'(o_data[2]), 32'hA5);
      step("byp");

`ifndef COMMON_CROSS_BUFFER4_DISPATCH_BROADCAST_EN
      // Capture on port 1, then head-of-line blocking
      drive(1'b1, 1, 8'h11, 4'b0000);
      step("cap.a");
      drive(1'b1, 1, 8'h22, 4'b0000);
      #3;
      chk("hol.data1", 32'(o_data[1]), 32'h11);
      chk("hol.ready", 32'(prev_o_ready), 32'h0);
      step("hol.b");
      drive(1'b1, 1, 8'h22, 4'b0010);
      #3;
      chk("hol.drain_ready", 32'(prev_o_ready), 32'h0);
      step("hol.c");
      #3;
      chk("hol.accept_ready", 32'(prev_o_ready), 32'h1);
      chk("hol.accept_data", 32'(o_data[1]), 32'h22);
      step("hol.d");

      // Independent ports: port 0 stalled full, port 3 bypasses
      drive(1'b1, 0, 8'h44, 4'b0000);
      step("ind.a");
      drive(1'b1, 3, 8'h33, 4'b1000);
      #3;
      chk("ind.valid3", 32'(o_valid[3]), 32'h1);
      chk("ind.data3", 32'(o_data[3]), 32'h33);
      chk("ind.data0", 32'(o_data[0]), 32'h44);
      step("ind.b");
      drive(1'b0, 0, 0, 4'b1111);
      step("ind.c");

      // Streaming: 16 beats, dests cycling 0..3
      a0 = acc_cnt;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, i % 4, 8'h80 + i, 4'b1111);
         step("stream");
      end
      chk("stream.accepted", 32'(acc_cnt - a0), 32'd16);
`else
      // Broadcast: port 0 bypasses, port 2 captures, follow-up stalls
      drive(1'b1, 4'b0101, 8'h5A, 4'b0001);
      #3;
      chk("bc.valid_vec", 32'(o_valid), 32'h5);
      chk("bc.data0", 32'(o_data[0]), 32'h5A);
      step("bc.a");
      drive(1'b1, 4'b0100, 8'h6B, 4'b0001);
      #3;
      chk("bc.stall_ready", 32'(prev_o_ready), 32'h0);
      chk("bc.data2", 32'(o_data[2]), 32'h5A);
      step("bc.b");
      drive(1'b1, 4'b0100, 8'h6B, 4'b0100);
      step("bc.c");
      #3;
      chk("bc.accept_ready", 32'(prev_o_ready), 32'h1);
      step("bc.d");
      drive(1'b1, 4'b0000, 8'h77, 4'b0000);
      #3;
      chk("bc.zero_ready", 32'(prev_o_ready), 32'h1);
      step("bc.e");
`endif

      // Randomized traffic honouring the hold-while-stalled rule
      stalled = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!stalled) begin
            valid = ($urandom_range(0, 3) != 0);
            dest  = DEST_IN_W'($urandom);
            data  = W'($urandom);
         end
         rdy = 4'($urandom);
         #3;
         stalled = valid && !prev_o_ready;
         step("rand");
      end

      // Reset mid-operation discards buffered beats
      drive(1'b1, 0, 8'hC0, 4'b0000);
      step("rst.fill0");
      drive(1'b1, 3, 8'hC3, 4'b0000);
      step("rst.fill3");
      drive(1'b0, 0, 0, 4'b0000);
      reset = 1'b1;
      step("rst.edge");
      reset = 1'b0;
      #3;
      chk("rst.valid_vec", 32'(o_valid), 32'h0);
      chk("rst.data0", 32'(o_data[0]), 32'h0);
      step("rst.after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
